// File: rtl/ps2_kbd_fsm_if.sv
// ps2_kbd_fsm_if -- bundles the PS/2 line inputs and the display-facing outputs
// of ps2_kbd_fsm.
//   master : keyboard/stimulus side, drives ps2_clk/ps2_data, observes outputs
//   slave  : ps2_kbd_fsm side
// Signals:
//   ps2_clk, ps2_data : raw PS/2 lines, asynchronous to the system clock
//   scan_code[7:0]    : last accepted make code
//   key_cnt[7:0]      : key-press counter
//   key_down          : tracked key is held
//   disp_en           : 1 = show scan_code digits, 0 = blank (equals key_down)
//   frame_err         : one-cycle pulse on a rejected frame
interface ps2_kbd_fsm_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic [7:0] key_cnt;
  logic       key_down;
  logic       disp_en;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  scan_code, key_cnt, key_down, disp_en, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_code, key_cnt, key_down, disp_en, frame_err
  );
endinterface

// File: rtl/ps2_kbd_fsm.sv
// ps2_kbd_fsm -- PS/2 keyboard receiver with make/break tracking, upstream of
// the seven-segment display path.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ps2_kbd_fsm_if.slave (PS/2 lines in; scan_code, key_cnt, key_down,
//           disp_en, frame_err out)
// Parameters:
//   SYNC_STAGES : synchronizer depth for ps2_clk/ps2_data (>= 2)
//   TIMEOUT     : idle clk cycles after which a partial frame is discarded
// Configuration macro:
//   PS2_BCD_CNT_EN : key_cnt counts packed BCD 00..99 instead of binary.
module ps2_kbd_fsm #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter logic [15:0] TIMEOUT     = 16'd50000
) (
  input logic         clk,
  input logic         rst_n,
  ps2_kbd_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESSED    = 2'd1,
    BREAK_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;

  // Synchronizers and falling-edge detect
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  // Idle-high reset values keep reset release from looking like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], bus.ps2_data};
      r_clk_prev <= w_clk_s;
    end
  end

  // Frame receiver
  logic [3:0]  r_bit_cnt;
  logic [9:0]  r_shift;
  logic [15:0] r_tmo;
  logic        r_rx_valid;
  logic [7:0]  r_rx_byte;
  logic        r_frame_err;
  logic [10:0] w_frame;
  logic        w_frame_ok;

  // Bits arrive LSB first into the top of r_shift; on the 11th edge the
  // incoming bit is the stop bit: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign w_frame    = {w_dat_s, r_shift};
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tmo       <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_byte   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_tmo <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= '0;
          if (w_frame_ok) begin
            r_rx_valid <= 1'b1;
            r_rx_byte  <= w_frame[8:1];
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_shift   <= {w_dat_s, r_shift[9:1]};
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_tmo == TIMEOUT - 16'd1) begin
          r_bit_cnt <= '0;
          r_tmo     <= '0;
        end else begin
          r_tmo <= r_tmo + 16'd1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  function automatic logic [7:0] cnt_inc(input logic [7:0] c);
`ifdef PS2_BCD_CNT_EN
    if (c[3:0] >= 4'd9) begin
      if (c[7:4] >= 4'd9) return 8'h00;
      return {c[7:4] + 4'd1, 4'h0};
    end
    return {c[7:4], c[3:0] + 4'd1};
`else
    return c + 8'd1;
`endif
  endfunction

  // Make/break tracker with registered outputs
  state_t     r_state;
  logic [7:0] r_scan_code;
  logic [7:0] r_key_cnt;
  logic       r_key_down;
  logic       r_disp_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_scan_code <= '0;
      r_key_cnt   <= '0;
      r_key_down  <= 1'b0;
      r_disp_en   <= 1'b0;
    end else if (r_rx_valid && r_rx_byte != BYTE_EXT) begin
      case (r_state)
        IDLE: begin
          if (r_rx_byte == BYTE_BREAK) begin
            r_state <= BREAK_WAIT;
          end else begin
            r_scan_code <= r_rx_byte;
            r_key_down  <= 1'b1;
            r_disp_en   <= 1'b1;
            r_key_cnt   <= cnt_inc(r_key_cnt);
            r_state     <= PRESSED;
          end
        end
        PRESSED: begin
          if (r_rx_byte == BYTE_BREAK) begin
            r_state <= BREAK_WAIT;
          end else if (r_rx_byte != r_scan_code) begin
            r_scan_code <= r_rx_byte;
            r_key_cnt   <= cnt_inc(r_key_cnt);
          end
        end
        BREAK_WAIT: begin
          if (r_key_down && r_rx_byte == r_scan_code) begin
            r_key_down <= 1'b0;
            r_disp_en  <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_state <= r_key_down ? PRESSED : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.scan_code = r_scan_code;
  assign bus.key_cnt   = r_key_cnt;
  assign bus.key_down  = r_key_down;
  assign bus.disp_en   = r_disp_en;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_fsm.sv
module tb_ps2_kbd_fsm;
  localparam int unsigned SYNC    = 3;
  localparam logic [15:0] TMO     = 16'd300;
  localparam int unsigned HALF    = 2;   // PS/2 half-period in clk cycles
  localparam int unsigned SETTLE  = 10;  // cycles after a frame before checking

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ps2_kbd_fsm_if bus ();

  ps2_kbd_fsm #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference model state
  logic [7:0] m_scan;
  logic [7:0] m_cnt;
  logic       m_down;
  logic       m_brk;   // a break prefix has been seen and awaits its code

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned err_seen = 0;
  int unsigned err_long = 0;
  logic        prev_err = 1'b0;
  logic        chk_en   = 1'b0;

  function automatic logic [7:0] model_inc(input logic [7:0] c);
    int unsigned d;
`ifdef PS2_BCD_CNT_EN
    d = (int'(c[7:4]) * 10 + int'(c[3:0]) + 1) % 100;
    return {4'(d / 10), 4'(d % 10)};
`else
    d = (int'(c) + 1) % 256;
    return 8'(d);
`endif
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) return;
    if (m_brk) begin
      m_brk = 1'b0;
      if (m_down && b == m_scan) m_down = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_down || b != m_scan) begin
      m_scan = b;
      m_down = 1'b1;
      m_cnt  = model_inc(m_cnt);
    end
  endtask

  task automatic model_reset();
    m_scan = 8'h00; m_cnt = 8'h00; m_down = 1'b0; m_brk = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // Continuous compare whenever outputs are expected to be stable
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) begin
      err_seen++;
      if (prev_err) err_long++;
    end
    prev_err = bus.frame_err;
    if (chk_en) begin
      n_chk++;
      if (bus.scan_code === m_scan && bus.key_cnt === m_cnt && bus.key_down === m_down &&
          bus.disp_en === m_down && bus.frame_err === 1'b0)
        n_pass++;
      else
        $display("FAIL cycle_cmp t=%0t: got scan=%02h cnt=%02h down=%b en=%b err=%b expected scan=%02h cnt=%02h down=%b en=%b err=0",
                 $time, bus.scan_code, bus.key_cnt, bus.key_down, bus.disp_en, bus.frame_err,
                 m_scan, m_cnt, m_down, m_down);
    end
  end

  // Drive the first n bits of frame f (f[0] first)
  task automatic send_bits(input logic [10:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      if (n == 11 && i == 10) chk_en = 1'b0;
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  task automatic send_frame(input logic [7:0] b, input int unsigned kind);
    logic [10:0] f;
    int unsigned e0;
    f[0]   = (kind == 3) ? 1'b1 : 1'b0;
    f[8:1] = b;
    f[9]   = ~(^b) ^ (kind == 1);
    f[10]  = (kind == 2) ? 1'b0 : 1'b1;
    e0 = err_seen;
    send_bits(f, 11);
    @(negedge clk);
    bus.ps2_data = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk("frame_err_pulses", 8'(err_seen - e0), (kind != 0) ? 8'd1 : 8'd0);
    if (kind == 0) model_byte(b);
    chk_en = 1'b1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_scan", bus.scan_code, 8'h00);
    chk("rst_cnt",  bus.key_cnt,   8'h00);
    chk("rst_down", {7'd0, bus.key_down},  8'h00);
    chk("rst_en",   {7'd0, bus.disp_en},   8'h00);
    chk("rst_err",  {7'd0, bus.frame_err}, 8'h00);
    rst_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [0:6];
    logic [7:0] b;
    int unsigned r, kind;
    pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h23; pool[3] = 8'hF0;
    pool[4] = 8'hF0; pool[5] = 8'hE0; pool[6] = 8'h00;

    rst_n = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    do_reset();

    // Single press
    send_frame(8'h1C, 0);
    chk("press_scan", bus.scan_code, 8'h1C);
    chk("press_down", {7'd0, bus.key_down}, 8'h01);
    chk("press_en",   {7'd0, bus.disp_en},  8'h01);
    chk("press_cnt",  bus.key_cnt, 8'h01);

    // Typematic repeat then release
    send_frame(8'h1C, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    chk("brk_pending_down", {7'd0, bus.key_down}, 8'h01);
    send_frame(8'h1C, 0);
    chk("rel_cnt",  bus.key_cnt, 8'h01);
    chk("rel_down", {7'd0, bus.key_down}, 8'h00);
    chk("rel_en",   {7'd0, bus.disp_en},  8'h00);
    chk("rel_scan", bus.scan_code, 8'h1C);

    // Even parity is rejected and leaves outputs alone
    send_frame(8'h1C, 1);
    chk("par_scan", bus.scan_code, 8'h1C);
    chk("par_cnt",  bus.key_cnt, 8'h01);

    // Partial frame discarded by timeout
    send_bits(11'h000, 3);
    repeat (int'(TMO) + 10) @(negedge clk);
    send_frame(8'h32, 0);
    chk("tmo_scan", bus.scan_code, 8'h32);
    chk("tmo_cnt",  bus.key_cnt, 8'h02);

    // Counter wrap
    do_reset();
`ifdef PS2_BCD_CNT_EN
    for (int unsigned i = 0; i < 100; i++) begin
      send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    end
    chk("wrap_cnt", bus.key_cnt, 8'h00);
    for (int unsigned i = 0; i < 10; i++) begin
      send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    end
    chk("bcd10_cnt", bus.key_cnt, 8'h10);
`else
    for (int unsigned i = 0; i < 256; i++) begin
      send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    end
    chk("wrap_cnt", bus.key_cnt, 8'h00);
    for (int unsigned i = 0; i < 10; i++) begin
      send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    end
    chk("bin10_cnt", bus.key_cnt, 8'h0A);
`endif

    // Second key held, release of the first with an extended prefix
    do_reset();
    send_frame(8'h1C, 0);
    send_frame(8'h32, 0);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    chk("ext_scan", bus.scan_code, 8'h32);
    chk("ext_down", {7'd0, bus.key_down}, 8'h01);
    chk("ext_cnt",  bus.key_cnt, 8'h02);

    // Randomized traffic including malformed frames
    for (int unsigned i = 0; i < 150; i++) begin
      r = $urandom_range(0, 6);
      b = (r == 6) ? 8'($urandom) : pool[r];
      r = $urandom_range(0, 19);
      kind = (r < 17) ? 0 : (r - 16);
      send_frame(b, kind);
    end

    // Reset in the middle of a frame
    send_bits(11'h5A4, 5);
    do_reset();
    send_frame(8'h23, 0);
    chk("post_rst_scan", bus.scan_code, 8'h23);
    chk("post_rst_cnt",  bus.key_cnt, 8'h01);

    chk("err_width", 8'(err_long), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
